demux_tdm1_4: RTL and testbench

Time-division 1-to-4 demultiplexer: receives a serial slot stream produced by a 4-input multiplexer scanned by a 2-bit slot counter and rebuilds the four parallel channels. Slot 0 is marked by a frame-sync pulse. Each complete frame is presented atomically on four registered outputs with a one-cycle valid strobe. The block sits at the receiving end of the TDM link, opposite the existing 4:1 multiplexer.

---
 rtl/demux_tdm1_4_pkg.sv | 17 +
 rtl/demux_tdm1_4_decod.sv | 21 ++
 rtl/demux_tdm1_4.sv | 121 ++++++++++++
 tb/tb_demux_tdm1_4.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/demux_tdm1_4_pkg.sv
// Shared definitions for the 1-to-4 TDM demultiplexer.
// Optional feature macro: DEMUX_ERRO_EN (enables the erro_sinc sync-loss port).
package demux_tdm1_4_pkg;

  // Receiver FSM states: waiting for frame sync, or receiving slots.
  typedef enum logic {
    ESPERA = 1'b0,
    RECEBE = 1'b1
  } estado_t;

  // Number of slots per frame and the width of a slot index.
  localparam int N_SLOTS = 4;
  localparam int SLOT_W  = 2;

  typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/demux_tdm1_4_decod.sv
// decod2_4: combinational 2-to-4 one-hot decoder with enable.
// Turns the current slot index into per-slot buffer write strobes.
// Optional feature macro: DEMUX_ERRO_EN (not used in this file).
module decod2_4
  import demux_tdm1_4_pkg::*;
(
  input  logic               en,
  input  slot_t              idx,
  output logic [N_SLOTS-1:0] y
);

  // One-hot strobe for the selected slot, all zero when disabled.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    y = '0;
    if (en) begin
      y[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_tdm1_4.sv
// demux_tdm1_4: rebuilds four parallel channels from a TDM slot stream.
// Slot 0 is marked by sinc. A completed frame loads s0..s3 together with a
// one-cycle valido strobe. Sync arriving mid-frame discards the partial
// frame and restarts at slot 0.
// Optional feature macro: DEMUX_ERRO_EN adds the registered erro_sinc pulse.
module demux_tdm1_4
  import demux_tdm1_4_pkg::*;
#(
  parameter int LARGURA = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [LARGURA-1:0] entrada,
  input  logic               sinc,
  output logic [LARGURA-1:0] s0,
  output logic [LARGURA-1:0] s1,
  output logic [LARGURA-1:0] s2,
  output logic [LARGURA-1:0] s3,
  output slot_t              sel,
  output logic               valido
`ifdef DEMUX_ERRO_EN
  ,
  output logic               erro_sinc
`endif
);

  estado_t            state_q, state_d;
  slot_t              cnt_q, cnt_d;
  logic [LARGURA-1:0] buf_q [N_SLOTS-1];
  logic [LARGURA-1:0] buf_d [N_SLOTS-1];
  logic [LARGURA-1:0] s_q   [N_SLOTS];
  logic [LARGURA-1:0] s_d   [N_SLOTS];
  logic               valido_q, valido_d;
`ifdef DEMUX_ERRO_EN
  logic               erro_q, erro_d;
`endif

  slot_t              slot_idx;
  logic               wr_active;
  logic [N_SLOTS-1:0] wr_stb;
  logic               frame_done;

  // Slot being written this cycle: a sync pulse always forces slot 0.
  always_comb begin
    slot_idx   = sinc ? '0 : cnt_q;
    wr_active  = enable && ((state_q == RECEBE) || sinc);
    frame_done = wr_stb[N_SLOTS-1];
    sel        = (state_q == RECEBE) ? slot_idx : '0;
  end

  decod2_4 u_decod (
    .en  (wr_active),
    .idx (slot_idx),
    .y   (wr_stb)
  );

  // Next-state logic: disable beats sync loss, which beats normal capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    s_d      = s_q;
    valido_d = 1'b0;
    if (!enable) begin
      state_d = ESPERA;
      cnt_d   = '0;
      for (int i = 0; i < N_SLOTS; i++) s_d[i] = '0;
    end else if (wr_active) begin
      state_d = RECEBE;
      cnt_d   = slot_idx + slot_t'(1);
      for (int i = 0; i < N_SLOTS - 1; i++) begin
        if (wr_stb[i]) buf_d[i] = entrada;
      end
      // The last slot goes straight to s3; slots 0..2 come from the buffer.
      if (frame_done) begin
        for (int i = 0; i < N_SLOTS - 1; i++) s_d[i] = buf_q[i];
        s_d[N_SLOTS-1] = entrada;
        valido_d       = 1'b1;
      end
    end
`ifdef DEMUX_ERRO_EN
    erro_d = enable && (state_q == RECEBE) && sinc && (cnt_q != '0);
`endif
  end

  // State, counter, capture buffer and output bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ESPERA;
      cnt_q    <= '0;
      // NOTE: the capture buffer is a handful of flops, not a RAM, so it is reset along with everything else.
      for (int i = 0; i < N_SLOTS - 1; i++) buf_q[i] <= '0;
      for (int i = 0; i < N_SLOTS; i++) s_q[i] <= '0;
      valido_q <= 1'b0;
`ifdef DEMUX_ERRO_EN
      erro_q   <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      s_q      <= s_d;
      valido_q <= valido_d;
`ifdef DEMUX_ERRO_EN
      erro_q   <= erro_d;
`endif
    end
  end

  assign s0     = s_q[0];
  assign s1     = s_q[1];
  assign s2     = s_q[2];
  assign s3     = s_q[3];
  assign valido = valido_q;
`ifdef DEMUX_ERRO_EN
  assign erro_sinc = erro_q;
`endif

endmodule

// File: tb/tb_demux_tdm1_4.sv
// Directed self-checking bench for demux_tdm1_4 (LARGURA = 4).
// erro_sinc checks are compiled in only when DEMUX_ERRO_EN is defined.
module tb_demux_tdm1_4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] entrada;
  logic         sinc;
  logic [W-1:0] s0, s1, s2, s3;
  logic [1:0]   sel;
  logic         valido;
`ifdef DEMUX_ERRO_EN
  logic         erro_sinc;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  demux_tdm1_4 #(.LARGURA(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .entrada (entrada),
    .sinc    (sinc),
    .s0      (s0),
    .s1      (s1),
    .s2      (s2),
    .s3      (s3),
    .sel     (sel),
    .valido  (valido)
`ifdef DEMUX_ERRO_EN
    ,
    .erro_sinc (erro_sinc)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic s, input logic [W-1:0] d);
    enable  = e;
    sinc    = s;
    entrada = d;
    #1;
  endtask

  task automatic check_out(input string tag, input logic v,
                           input logic [W-1:0] e0, input logic [W-1:0] e1,
                           input logic [W-1:0] e2, input logic [W-1:0] e3);
    check({tag, ".valido"}, 32'(valido), 32'(v));
    check({tag, ".s"}, {16'h0, s0, s1, s2, s3}, {16'h0, e0, e1, e2, e3});
  endtask

  // Send one four-slot frame; sinc on slot 0 only if with_sync is set.
  task automatic send_frame(input string tag, input logic with_sync,
                            input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input logic [W-1:0] d2, input logic [W-1:0] d3);
    logic [W-1:0] d [4];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, with_sync && (i == 0), d[i]);
      check({tag, ".sel"}, 32'(sel), 32'(i));
      if (i != 0) check({tag, ".valido_mid"}, 32'(valido), 32'd0);
      tick();
    end
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b1;
    sinc    = 1'b0;
    entrada = '0;
    tick();
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 4'h0);
    check_out("reset", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    check("reset.sel", 32'(sel), 32'd0);
`ifdef DEMUX_ERRO_EN
    check("reset.erro", 32'(erro_sinc), 32'd0);
`endif

    // Basic frame 1,0,1,1.
    send_frame("frame1", 1'b1, 4'h1, 4'h0, 4'h1, 4'h1);
    check_out("frame1", 1'b1, 4'h1, 4'h0, 4'h1, 4'h1);

    // Flywheel: three back-to-back frames, sync only on the first.
    send_frame("flyA", 1'b1, 4'h3, 4'hC, 4'h5, 4'hA);
    check_out("flyA", 1'b1, 4'h3, 4'hC, 4'h5, 4'hA);
    send_frame("flyB", 1'b0, 4'h9, 4'h8, 4'h7, 4'h6);
    check_out("flyB", 1'b1, 4'h9, 4'h8, 4'h7, 4'h6);
    send_frame("flyC", 1'b0, 4'hE, 4'hD, 4'h2, 4'hF);
    check_out("flyC", 1'b1, 4'hE, 4'hD, 4'h2, 4'hF);

    // Sync loss: sinc at t and t+2; frame restarts at t+2.
    drive(1'b1, 1'b1, 4'h5);            // t
    tick();
    drive(1'b1, 1'b0, 4'h6);            // t+1
    check("loss.sel1", 32'(sel), 32'd1);
    tick();
    drive(1'b1, 1'b1, 4'h7);            // t+2, offending sync
    check("loss.sel_restart", 32'(sel), 32'd0);
    tick();
    drive(1'b1, 1'b0, 4'h8);            // t+3
`ifdef DEMUX_ERRO_EN
    check("loss.erro_pulse", 32'(erro_sinc), 32'd1);
`endif
    check("loss.sel_t3", 32'(sel), 32'd1);
    tick();
    drive(1'b1, 1'b0, 4'h9);            // t+4: no valido, outputs hold frame C
`ifdef DEMUX_ERRO_EN
    check("loss.erro_end", 32'(erro_sinc), 32'd0);
`endif
    check_out("loss.t4_hold", 1'b0, 4'hE, 4'hD, 4'h2, 4'hF);
    tick();
    drive(1'b1, 1'b0, 4'hA);            // t+5
    check("loss.sel_t5", 32'(sel), 32'd3);
    tick();
    check_out("loss.t6", 1'b1, 4'h7, 4'h8, 4'h9, 4'hA);

    // Disable mid-frame, then data ignored until a fresh sinc.
    drive(1'b1, 1'b1, 4'h3);
    tick();
    drive(1'b0, 1'b0, 4'h4);
    tick();
    drive(1'b1, 1'b0, 4'hF);
    check_out("dis.cleared", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    check("dis.sel", 32'(sel), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      drive(1'b1, 1'b0, 4'hF);
      check_out("dis.ignored", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      check("dis.sel_idle", 32'(sel), 32'd0);
    end
    send_frame("reen", 1'b1, 4'h2, 4'h4, 4'h6, 4'h8);
    check_out("reen", 1'b1, 4'h2, 4'h4, 4'h6, 4'h8);

    // Reset mid-frame: partial frame lost, next full frame intact.
    drive(1'b1, 1'b1, 4'hA);
    tick();
    drive(1'b1, 1'b0, 4'h5);
    tick();
    reset = 1'b1;
    drive(1'b1, 1'b0, 4'h0);
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 4'h0);
    check_out("rst_mid", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    check("rst_mid.sel", 32'(sel), 32'd0);
    send_frame("after_rst", 1'b1, 4'h1, 4'h2, 4'h3, 4'h4);
    check_out("after_rst", 1'b1, 4'h1, 4'h2, 4'h3, 4'h4);
    drive(1'b0, 1'b0, 4'h0);
    tick();
    check("after_rst.valido_drop", 32'(valido), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
